bounce_sprite: RTL and testbench

BOUNCE_SPRITE -- requirements
Module: bounce_sprite

---
 rtl/bounce_sprite.sv | 165 ++++++++++++++++
 tb/tb_bounce_sprite.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_sprite.sv
// Bouncing sprite game object: position/direction/state advance once per frame on fsync,
// hit/miss are one-cycle registered pulses, active/pixel are combinational from the scan position.
module bounce_sprite #(
    parameter int          HRES         = 1280,
    parameter int          VRES         = 720,
    parameter int          OBJ_W        = 50,
    parameter int          OBJ_H        = 50,
    parameter int          VEL_X        = 12,
    parameter int          VEL_Y        = 12,
    parameter int          PADDLE_W     = 200,
    parameter int          PADDLE_H     = 20,
    parameter int          START_X      = 615,
    parameter int          START_Y      = 100,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [23:0] COLOR        = 24'h00FF90
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               enable,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic signed [11:0] paddle_x,
    output logic [7:0]         pixel [0:2],
    output logic               active,
    output logic               hit,
    output logic               miss,
    output logic [7:0]         miss_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        MOVE  = 2'd2,
        MISS  = 2'd3
    } state_t;

    localparam logic signed [12:0] XMAX       = 13'(HRES - OBJ_W);
    localparam logic signed [12:0] YMAX       = 13'(VRES - PADDLE_H - OBJ_H);
    localparam logic signed [12:0] VX         = 13'(VEL_X);
    localparam logic signed [12:0] VY         = 13'(VEL_Y);
    localparam logic signed [12:0] OW1        = 13'(OBJ_W - 1);
    localparam logic signed [12:0] OH1        = 13'(OBJ_H - 1);
    localparam logic signed [12:0] PW1        = 13'(PADDLE_W - 1);
    localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);

    state_t             st;
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic               left;
    logic               up;
    logic [15:0]        frame_cnt;

    logic signed [12:0] x13;
    logic signed [12:0] y13;
    logic signed [12:0] h13;
    logic signed [12:0] v13;
    logic signed [12:0] pad13;
    logic signed [12:0] nx;
    logic signed [12:0] ny;
    logic signed [12:0] nx_clamped;
    logic               next_left;
    logic               overlap;

    assign x13   = 13'(x);
    assign y13   = 13'(y);
    assign h13   = 13'(hpos);
    assign v13   = 13'(vpos);
    assign pad13 = 13'(paddle_x);
    assign state = st;

    // Paddle overlap uses the already-clamped x so a wall bounce and paddle test agree in a corner frame.
    always_comb begin
        nx         = left ? (x13 - VX) : (x13 + VX);
        ny         = up   ? (y13 - VY) : (y13 + VY);
        nx_clamped = nx;
        next_left  = left;
        if (nx > XMAX) begin
            nx_clamped = XMAX;
            next_left  = 1'b1;
        end else if (nx < 13'sd0) begin
            nx_clamped = '0;
            next_left  = 1'b0;
        end
        overlap = ((nx_clamped + OW1) >= pad13) && (nx_clamped <= (pad13 + PW1));
    end

    assign active = (h13 >= x13) && (h13 <= (x13 + OW1)) &&
                    (v13 >= y13) && (v13 <= (y13 + OH1));

    always_comb begin
        pixel[0] = 8'h00;
        pixel[1] = 8'h00;
        pixel[2] = 8'h00;
        if (active) begin
            pixel[0] = COLOR[7:0];
            pixel[1] = COLOR[15:8];
            pixel[2] = COLOR[23:16];
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            x          <= 12'(START_X);
            y          <= 12'(START_Y);
            left       <= 1'b0;
            up         <= 1'b0;
            frame_cnt  <= '0;
            miss_count <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (fsync) begin
                if (!enable) begin
                    st <= IDLE;
                end else begin
                    case (st)
                        IDLE, MISS: begin
                            x         <= 12'(START_X);
                            y         <= 12'(START_Y);
                            left      <= 1'b0;
                            up        <= 1'b0;
                            frame_cnt <= '0;
                            st        <= SERVE;
                        end
                        SERVE: begin
                            frame_cnt <= frame_cnt + 16'd1;
                            if (frame_cnt == SERVE_LAST) begin
                                st <= MOVE;
                            end
                        end
                        MOVE: begin
                            x    <= nx_clamped[11:0];
                            left <= next_left;
                            if (ny < 13'sd0) begin
                                y  <= '0;
                                up <= 1'b0;
                            end else if (ny < YMAX) begin
                                y <= ny[11:0];
                            end else begin
                                y <= YMAX[11:0];
                                if (overlap) begin
                                    up  <= 1'b1;
                                    hit <= 1'b1;
                                end else begin
                                    miss <= 1'b1;
                                    st   <= MISS;
                                    if (miss_count != 8'hFF) begin
                                        miss_count <= miss_count + 8'd1;
                                    end
                                end
                            end
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bounce_sprite.sv
// Directed bench for bounce_sprite: default instance walks a full hand-traced rally; a second
// instance starts next to the bottom-right corner to exercise simultaneous X/Y reversal.
module tb_bounce_sprite;

    logic               pixel_clk = 1'b0;
    logic               rst       = 1'b1;
    logic               fsync     = 1'b0;
    logic               enable    = 1'b0;
    logic               fsync_c   = 1'b0;
    logic               enable_c  = 1'b0;
    logic signed [11:0] hpos      = '0;
    logic signed [11:0] vpos      = '0;
    logic signed [11:0] paddle_x  = '0;

    logic [7:0] pixel [0:2];
    logic       active, hit, miss;
    logic [7:0] miss_count;
    logic [1:0] state;

    logic [7:0] pixel_c [0:2];
    logic       active_c, hit_c, miss_c;
    logic [7:0] miss_count_c;
    logic [1:0] state_c;

    int checks = 0;
    int errors = 0;

    always #5 pixel_clk = ~pixel_clk;

    bounce_sprite dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .fsync     (fsync),
        .enable    (enable),
        .hpos      (hpos),
        .vpos      (vpos),
        .paddle_x  (paddle_x),
        .pixel     (pixel),
        .active    (active),
        .hit       (hit),
        .miss      (miss),
        .miss_count(miss_count),
        .state     (state)
    );

    bounce_sprite #(
        .START_X     (1225),
        .START_Y     (645),
        .SERVE_FRAMES(1)
    ) dut_c (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .fsync     (fsync_c),
        .enable    (enable_c),
        .hpos      (hpos),
        .vpos      (vpos),
        .paddle_x  (paddle_x),
        .pixel     (pixel_c),
        .active    (active_c),
        .hit       (hit_c),
        .miss      (miss_c),
        .miss_count(miss_count_c),
        .state     (state_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit c);
        @(negedge pixel_clk);
        if (c) fsync_c = 1'b1;
        else   fsync   = 1'b1;
        @(negedge pixel_clk);
        fsync   = 1'b0;
        fsync_c = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0);
    endtask

    task automatic probe(input bit c, input int h, input int v, input logic e, input string tag);
        hpos = 12'(h);
        vpos = 12'(v);
        #1;
        chk(tag, c ? active_c : active, e);
    endtask

    // Pins x and y exactly: inside at (ex,ey), outside one pixel left and one line above.
    task automatic pos_chk(input bit c, input int ex, input int ey, input string tag);
        probe(c, ex,      ey,      1'b1, {tag, "_tl"});
        probe(c, ex - 1,  ey,      1'b0, {tag, "_left"});
        probe(c, ex,      ey - 1,  1'b0, {tag, "_above"});
        probe(c, ex + 49, ey + 49, 1'b1, {tag, "_br"});
    endtask

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        pos_chk(1'b0, 615, 100, "rst_pos");
        hpos = 12'sd615; vpos = 12'sd100; #1;
        chk("pix_blue", pixel[0], 8'h90);
        chk("pix_green", pixel[1], 8'hFF);
        chk("pix_red", pixel[2], 8'h00);
        hpos = 12'sd665; #1;
        chk("edge_active", active, 0);
        chk("edge_pix", {pixel[2], pixel[1], pixel[0]}, 0);

        @(negedge pixel_clk);
        rst = 1'b0;
        pulse(1'b0);
        chk("idle_disabled", state, 0);

        // Corner instance: bottom-right wall and paddle edge touching in the same frame.
        paddle_x = 12'sd1279;
        enable_c = 1'b1;
        pulse(1'b1);
        chk("c_serve", state_c, 1);
        pulse(1'b1);
        chk("c_move", state_c, 2);
        pos_chk(1'b1, 1225, 645, "c_start");
        pulse(1'b1);
        chk("c_hit", hit_c, 1);
        chk("c_nomiss", miss_c, 0);
        chk("c_state", state_c, 2);
        pos_chk(1'b1, 1230, 650, "c_corner");
        @(negedge pixel_clk);
        chk("c_hit_clear", hit_c, 0);
        pulse(1'b1);
        pos_chk(1'b1, 1218, 638, "c_reversed");
        enable_c = 1'b0;

        // Main rally.
        paddle_x = 12'sd1100;
        enable   = 1'b1;
        pulse(1'b0);
        chk("serve", state, 1);
        frames(59);
        chk("serve_hold", state, 1);
        frames(1);
        chk("move", state, 2);
        pos_chk(1'b0, 615, 100, "move_start");
        frames(45);
        pos_chk(1'b0, 1155, 640, "k45");
        chk("k45_nohit", hit, 0);
        frames(1);
        chk("k46_hit", hit, 1);
        chk("k46_state", state, 2);
        pos_chk(1'b0, 1167, 650, "k46");
        @(negedge pixel_clk);
        chk("k46_hit_clear", hit, 0);
        paddle_x = 12'sd62;
        frames(6);
        pos_chk(1'b0, 1230, 578, "k52_rwall");
        frames(1);
        pos_chk(1'b0, 1218, 566, "k53");
        frames(47);
        pos_chk(1'b0, 654, 2, "k100");
        frames(1);
        pos_chk(1'b0, 642, 0, "k101_top");
        frames(1);
        pos_chk(1'b0, 630, 12, "k102");
        frames(52);
        pos_chk(1'b0, 6, 636, "k154");
        frames(1);
        pos_chk(1'b0, 0, 648, "k155_lwall");
        frames(1);
        chk("k156_miss", miss, 1);
        chk("k156_nohit", hit, 0);
        chk("k156_state", state, 3);
        chk("k156_count", miss_count, 1);
        pos_chk(1'b0, 12, 650, "k156");
        @(negedge pixel_clk);
        chk("k156_miss_clear", miss, 0);

        pulse(1'b0);
        chk("reserve", state, 1);
        pos_chk(1'b0, 615, 100, "reserve_pos");
        frames(59);
        chk("reserve_hold", state, 1);
        frames(1);
        chk("remove", state, 2);
        frames(1);
        pos_chk(1'b0, 627, 112, "remove_pos");

        // Asynchronous reset in the middle of a clock phase while moving.
        @(negedge pixel_clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_count", miss_count, 0);
        chk("arst_hit", hit, 0);
        chk("arst_miss", miss, 0);
        pos_chk(1'b0, 615, 100, "arst_pos");
        pulse(1'b0);
        chk("arst_hold", state, 0);
        @(negedge pixel_clk);
        rst = 1'b0;
        pulse(1'b0);
        chk("post_rst_serve", state, 1);
        frames(60);
        chk("post_rst_move", state, 2);
        frames(1);
        pos_chk(1'b0, 627, 112, "post_rst_pos");

        enable = 1'b0;
        pulse(1'b0);
        chk("dis_idle", state, 0);
        pos_chk(1'b0, 627, 112, "dis_frozen");
        pulse(1'b0);
        chk("dis_idle2", state, 0);
        enable = 1'b1;
        pulse(1'b0);
        chk("reen_serve", state, 1);
        pos_chk(1'b0, 615, 100, "reen_pos");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
